csr_access_ctrl: RTL and testbench

- Sequencer and arbiter in front of the CSR unit, driving its en/we/addr/data/busy handshake.
- Shares the CSR unit between two requesters: the instruction port (Zicsr CSRRW/CSRRS/CSRRC read-modify-write) and the trap port (single-word writes such as mepc, mcause or mtval).
- Sits between decode/execute, the trap logic and the CSR unit.

---
 rtl/csr_access_ctrl.sv | 216 +++++++++++++++++++++
 tb/tb_csr_access_ctrl.sv | 312 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/csr_access_ctrl.sv
// rtl/csr_access_ctrl.sv - CSR access sequencer/arbiter for instruction RMW and trap writes
// Trap writes take fixed priority; instruction ops run as read, optional write, then a one-cycle ack.
module csr_access_ctrl #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 12,
  parameter int TIMEOUT    = 15
) (
  input  logic                  clk_i,
  input  logic                  rst_i,

  input  logic                  ins_valid_i,
  input  logic [1:0]            ins_op_i,
  input  logic                  ins_nowrite_i,
  input  logic [ADDR_WIDTH-1:0] ins_addr_i,
  input  logic [DATA_WIDTH-1:0] ins_operand_i,
  output logic                  ins_ack_o,
  output logic [DATA_WIDTH-1:0] ins_rdata_o,
  output logic                  ins_err_o,

  input  logic                  trap_valid_i,
  input  logic [ADDR_WIDTH-1:0] trap_addr_i,
  input  logic [DATA_WIDTH-1:0] trap_data_i,
  output logic                  trap_ack_o,
  output logic                  trap_err_o,

  output logic                  csr_en_o,
  output logic                  csr_we_o,
  output logic [ADDR_WIDTH-1:0] csr_addr_o,
  output logic [DATA_WIDTH-1:0] csr_wdata_o,
  input  logic [DATA_WIDTH-1:0] csr_rdata_i,
  input  logic                  csr_busy_i,

  output logic                  ctrl_busy_o
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_RD_ISSUE,
    S_RD_WAIT,
    S_WR_ISSUE,
    S_WR_WAIT,
    S_DONE
  } state_t;

  localparam logic [1:0] OP_RW = 2'b01;
  localparam logic [1:0] OP_RS = 2'b10;
  localparam logic [1:0] OP_RC = 2'b11;
  localparam int         CNT_W = $clog2(TIMEOUT + 1);

  state_t                state_q;
  state_t                state_d;

  logic                  owner_trap_q;
  logic [ADDR_WIDTH-1:0] lat_addr_q;
  logic [DATA_WIDTH-1:0] lat_operand_q;
  logic [1:0]            lat_op_q;
  logic                  lat_nowrite_q;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic [DATA_WIDTH-1:0] old_q;
  logic                  err_q;
  logic                  seen_busy_q;
  logic [CNT_W-1:0]      tmo_cnt_q;

  logic                  done_now;
  logic                  timed_out;
  logic                  need_wr;
  logic                  ro_addr;
  logic [DATA_WIDTH-1:0] new_val;

  // An access completes on the first idle cycle after busy has been seen high.
  assign done_now  = seen_busy_q & ~csr_busy_i;
  assign timed_out = ~done_now & (tmo_cnt_q == CNT_W'(TIMEOUT - 1));
  assign need_wr   = (lat_op_q == OP_RW) |
                     (((lat_op_q == OP_RS) | (lat_op_q == OP_RC)) & ~lat_nowrite_q);
  assign ro_addr   = (lat_addr_q[ADDR_WIDTH-1 -: 2] == 2'b11);

  always_comb begin
    new_val = csr_rdata_i;
    case (lat_op_q)
      OP_RW:   new_val = lat_operand_q;
      OP_RS:   new_val = csr_rdata_i | lat_operand_q;
      OP_RC:   new_val = csr_rdata_i & ~lat_operand_q;
      default: new_val = csr_rdata_i;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (trap_valid_i) begin
          state_d = S_WR_ISSUE;
        end else if (ins_valid_i) begin
          state_d = S_RD_ISSUE;
        end
      end
      S_RD_ISSUE: state_d = S_RD_WAIT;
      S_RD_WAIT: begin
        if (done_now) begin
          state_d = (need_wr & ~ro_addr) ? S_WR_ISSUE : S_DONE;
        end else if (timed_out) begin
          state_d = S_DONE;
        end
      end
      S_WR_ISSUE: state_d = S_WR_WAIT;
      S_WR_WAIT: begin
        if (done_now | timed_out) begin
          state_d = S_DONE;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      owner_trap_q  <= 1'b0;
      lat_addr_q    <= '0;
      lat_operand_q <= '0;
      lat_op_q      <= '0;
      lat_nowrite_q <= 1'b0;
      wdata_q       <= '0;
      old_q         <= '0;
      err_q         <= 1'b0;
      seen_busy_q   <= 1'b0;
      tmo_cnt_q     <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (trap_valid_i) begin
            owner_trap_q <= 1'b1;
            lat_addr_q   <= trap_addr_i;
            wdata_q      <= trap_data_i;
            old_q        <= '0;
            err_q        <= 1'b0;
          end else if (ins_valid_i) begin
            owner_trap_q  <= 1'b0;
            lat_addr_q    <= ins_addr_i;
            lat_operand_q <= ins_operand_i;
            lat_op_q      <= ins_op_i;
            lat_nowrite_q <= ins_nowrite_i;
            old_q         <= '0;
            err_q         <= 1'b0;
          end
        end
        S_RD_ISSUE, S_WR_ISSUE: begin
          seen_busy_q <= 1'b0;
          tmo_cnt_q   <= '0;
        end
        S_RD_WAIT, S_WR_WAIT: begin
          tmo_cnt_q <= tmo_cnt_q + CNT_W'(1);
          if (csr_busy_i) begin
            seen_busy_q <= 1'b1;
          end
          // Old value is kept even on a rejected write so the requester still sees it.
          if ((state_q == S_RD_WAIT) && done_now) begin
            old_q   <= csr_rdata_i;
            wdata_q <= new_val;
            if (need_wr & ro_addr) begin
              err_q <= 1'b1;
            end
          end else if (timed_out) begin
            err_q <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    csr_en_o    = 1'b0;
    csr_we_o    = 1'b0;
    csr_addr_o  = '0;
    csr_wdata_o = '0;
    ins_ack_o   = 1'b0;
    ins_rdata_o = '0;
    ins_err_o   = 1'b0;
    trap_ack_o  = 1'b0;
    trap_err_o  = 1'b0;
    ctrl_busy_o = (state_q != S_IDLE);
    case (state_q)
      S_RD_ISSUE: begin
        csr_en_o   = 1'b1;
        csr_addr_o = lat_addr_q;
      end
      S_WR_ISSUE: begin
        csr_en_o    = 1'b1;
        csr_we_o    = 1'b1;
        csr_addr_o  = lat_addr_q;
        csr_wdata_o = wdata_q;
      end
      S_DONE: begin
        if (owner_trap_q) begin
          trap_ack_o = 1'b1;
          trap_err_o = err_q;
        end else begin
          ins_ack_o   = 1'b1;
          ins_rdata_o = old_q;
          ins_err_o   = err_q;
        end
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_csr_access_ctrl.sv
// tb/tb_csr_access_ctrl.sv - directed bench with a cycle-schedule model of csr_access_ctrl
module tb_csr_access_ctrl;

  localparam int DW  = 32;
  localparam int AW  = 12;
  localparam int TMO = 15;
  localparam int NC  = 1024;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          ins_valid = 1'b0;
  logic [1:0]    ins_op = '0;
  logic          ins_nowrite = 1'b0;
  logic [AW-1:0] ins_addr = '0;
  logic [DW-1:0] ins_operand = '0;
  logic          ins_ack;
  logic [DW-1:0] ins_rdata;
  logic          ins_err;
  logic          trap_valid = 1'b0;
  logic [AW-1:0] trap_addr = '0;
  logic [DW-1:0] trap_data = '0;
  logic          trap_ack;
  logic          trap_err;
  logic          csr_en;
  logic          csr_we;
  logic [AW-1:0] csr_addr;
  logic [DW-1:0] csr_wdata;
  logic [DW-1:0] csr_rdata;
  logic          csr_busy;
  logic          ctrl_busy;

  always #5 clk = ~clk;

  csr_access_ctrl #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .TIMEOUT(TMO)) dut (
    .clk_i(clk), .rst_i(rst),
    .ins_valid_i(ins_valid), .ins_op_i(ins_op), .ins_nowrite_i(ins_nowrite),
    .ins_addr_i(ins_addr), .ins_operand_i(ins_operand),
    .ins_ack_o(ins_ack), .ins_rdata_o(ins_rdata), .ins_err_o(ins_err),
    .trap_valid_i(trap_valid), .trap_addr_i(trap_addr), .trap_data_i(trap_data),
    .trap_ack_o(trap_ack), .trap_err_o(trap_err),
    .csr_en_o(csr_en), .csr_we_o(csr_we), .csr_addr_o(csr_addr), .csr_wdata_o(csr_wdata),
    .csr_rdata_i(csr_rdata), .csr_busy_i(csr_busy), .ctrl_busy_o(ctrl_busy)
  );

  function automatic logic [DW-1:0] preset(input logic [AW-1:0] a);
    case (a)
      12'h340: return 32'h1234_5678;
      12'hC00: return 32'hCAFE_0001;
      default: return 32'h0;
    endcase
  endfunction

  // CSR unit: latches read data on the strobe, raises busy for the following cycle.
  logic [DW-1:0] unit_mem [4096];
  logic          mem_loaded = 1'b0;
  logic          busy_stuck_lo = 1'b0;
  logic          busy_r = 1'b0;
  logic [DW-1:0] rd_hold = '0;
  always @(posedge clk) begin
    if (!mem_loaded) begin
      for (int i = 0; i < 4096; i++) unit_mem[i] <= preset(12'(i));
      mem_loaded <= 1'b1;
    end else if (csr_en) begin
      rd_hold <= unit_mem[csr_addr];
      if (csr_we) unit_mem[csr_addr] <= csr_wdata;
    end
    busy_r <= csr_en & ~busy_stuck_lo;
  end
  assign csr_busy  = busy_r;
  assign csr_rdata = rd_hold;

  // Expected outputs per cycle, filled from latency rules when a request is launched.
  logic [DW-1:0] ref_mem [4096];
  bit            exp_en [NC];
  bit            exp_we [NC];
  logic [AW-1:0] exp_addr [NC];
  logic [DW-1:0] exp_wdata [NC];
  bit            exp_iack [NC];
  logic [DW-1:0] exp_irdata [NC];
  bit            exp_ierr [NC];
  bit            exp_tack [NC];
  bit            exp_terr [NC];
  bit            exp_busy [NC];

  int            n_vec = 0;
  int            n_err = 0;
  int            cyc = 0;
  bit            prev_en = 1'b0;
  bit            saw_iack, saw_tack;
  int            iack_cyc, tack_cyc;
  logic [DW-1:0] iack_rdata;
  logic          iack_err, tack_err;
  int            en_cnt, we_cnt;
  logic [DW-1:0] last_wdata;

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s cyc=%0d got=%h want=%h", name, cyc, act, exp);
    end
  endtask

  task automatic clear_exp(input int from);
    for (int c = from; c < NC; c++) begin
      exp_en[c] = 0; exp_we[c] = 0; exp_addr[c] = '0; exp_wdata[c] = '0;
      exp_iack[c] = 0; exp_irdata[c] = '0; exp_ierr[c] = 0;
      exp_tack[c] = 0; exp_terr[c] = 0; exp_busy[c] = 0;
    end
  endtask

  task automatic compare_cycle();
    int c;
    c = (cyc < NC) ? cyc : NC - 1;
    chk("csr_en", csr_en, exp_en[c]);
    chk("csr_we", csr_we, exp_we[c]);
    if (exp_en[c]) chk("csr_addr", csr_addr, exp_addr[c]);
    if (exp_we[c]) chk("csr_wdata", csr_wdata, exp_wdata[c]);
    chk("ins_ack", ins_ack, exp_iack[c]);
    if (exp_iack[c]) begin
      chk("ins_rdata", ins_rdata, exp_irdata[c]);
      chk("ins_err", ins_err, exp_ierr[c]);
    end
    chk("trap_ack", trap_ack, exp_tack[c]);
    if (exp_tack[c]) chk("trap_err", trap_err, exp_terr[c]);
    chk("ctrl_busy", ctrl_busy, exp_busy[c]);
    chk("en_back_to_back", prev_en & csr_en, 0);
    chk("we_without_en", csr_we & ~csr_en, 0);
    prev_en = csr_en;
    saw_iack = ins_ack;
    saw_tack = trap_ack;
    if (csr_en) en_cnt++;
    if (csr_en && csr_we) begin we_cnt++; last_wdata = csr_wdata; end
    if (ins_ack) begin iack_cyc = cyc; iack_rdata = ins_rdata; iack_err = ins_err; end
    if (trap_ack) begin tack_cyc = cyc; tack_err = trap_err; end
  endtask

  task automatic step();
    @(negedge clk);
    compare_cycle();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic plan_ins(input int s, input logic [1:0] op, input logic nw, input logic [AW-1:0] a,
                          input logic [DW-1:0] opd, input bit stuck);
    logic [DW-1:0] old, nv;
    bit wr, ro;
    int ack_c;
    old = ref_mem[a];
    case (op)
      2'b01:   nv = opd;
      2'b10:   nv = old | opd;
      2'b11:   nv = old & ~opd;
      default: nv = old;
    endcase
    wr = (op == 2'b01) || ((op == 2'b10 || op == 2'b11) && !nw);
    ro = (a[11:10] == 2'b11);
    exp_en[s+1] = 1; exp_addr[s+1] = a;
    if (stuck) begin
      ack_c = s + 2 + TMO;
      exp_irdata[ack_c] = '0; exp_ierr[ack_c] = 1;
    end else if (wr && !ro) begin
      exp_en[s+4] = 1; exp_we[s+4] = 1; exp_addr[s+4] = a; exp_wdata[s+4] = nv;
      ref_mem[a] = nv;
      ack_c = s + 7;
      exp_irdata[ack_c] = old; exp_ierr[ack_c] = 0;
    end else begin
      ack_c = s + 4;
      exp_irdata[ack_c] = old; exp_ierr[ack_c] = wr && ro;
    end
    exp_iack[ack_c] = 1;
    for (int c = s + 1; c <= ack_c; c++) exp_busy[c] = 1;
  endtask

  task automatic plan_trap(input int s, input logic [AW-1:0] a, input logic [DW-1:0] d);
    exp_en[s+1] = 1; exp_we[s+1] = 1; exp_addr[s+1] = a; exp_wdata[s+1] = d;
    ref_mem[a] = d;
    exp_tack[s+4] = 1; exp_terr[s+4] = 0;
    for (int c = s + 1; c <= s + 4; c++) exp_busy[c] = 1;
  endtask

  task automatic start_counts();
    en_cnt = 0; we_cnt = 0; last_wdata = 32'hA5A5_A5A5;
    iack_cyc = -1; tack_cyc = -1; iack_rdata = 'x; iack_err = 1'bx; tack_err = 1'bx;
  endtask

  task automatic run_until(input bit want_i, input bit want_t);
    bit got_i, got_t;
    got_i = !want_i;
    got_t = !want_t;
    for (int k = 0; k < 60 && !(got_i && got_t); k++) begin
      step();
      if (saw_iack && !got_i) begin got_i = 1; ins_valid = 0; end
      if (saw_tack && !got_t) begin got_t = 1; trap_valid = 0; end
    end
    if (want_i) chk("ins_ack_wait", got_i, 1);
    if (want_t) chk("trap_ack_wait", got_t, 1);
    ins_valid = 0;
    trap_valid = 0;
    step();
  endtask

  // Launch one instruction request; request fields are scrambled once latched.
  task automatic do_ins(input logic [1:0] op, input logic nw, input logic [AW-1:0] a,
                        input logic [DW-1:0] opd, input bit stuck, output int s);
    s = cyc;
    plan_ins(s, op, nw, a, opd, stuck);
    start_counts();
    ins_valid = 1; ins_op = op; ins_nowrite = nw; ins_addr = a; ins_operand = opd;
    step();
    ins_op = ~op; ins_nowrite = ~nw; ins_addr = a ^ 12'hFFF; ins_operand = ~opd;
    run_until(1, 0);
  endtask

  task automatic reset_mid(input logic [1:0] op, input logic [AW-1:0] a, input logic [DW-1:0] opd,
                           input int off, input string tag);
    int s;
    s = cyc;
    plan_ins(s, op, 1'b0, a, opd, 1'b0);
    start_counts();
    ins_valid = 1; ins_op = op; ins_nowrite = 0; ins_addr = a; ins_operand = opd;
    repeat (off) step();
    rst = 1;
    ins_valid = 0;
    #1;
    chk({tag, "_en"}, csr_en, 0);
    chk({tag, "_we"}, csr_we, 0);
    chk({tag, "_addr"}, csr_addr, 0);
    chk({tag, "_wdata"}, csr_wdata, 0);
    chk({tag, "_busy"}, ctrl_busy, 0);
    chk({tag, "_iack"}, ins_ack, 0);
    clear_exp(cyc);
    step();
    step();
    rst = 0;
    repeat (10) step();
    chk({tag, "_no_ack"}, iack_cyc, -1);
  endtask

  initial begin
    int s;
    for (int i = 0; i < 4096; i++) ref_mem[i] = preset(12'(i));
    clear_exp(0);
    start_counts();
    repeat (3) @(posedge clk);
    #1;
    chk("rst_en", csr_en, 0);
    chk("rst_we", csr_we, 0);
    chk("rst_ins_ack", ins_ack, 0);
    chk("rst_trap_ack", trap_ack, 0);
    chk("rst_ctrl_busy", ctrl_busy, 0);
    rst = 0;
    cyc = 0;
    step();
    step();

    do_ins(2'b01, 0, 12'h340, 32'hDEAD_BEEF, 0, s);
    chk("rw_latency", iack_cyc - s, 7);
    chk("rw_rdata", iack_rdata, 32'h1234_5678);
    chk("rw_wdata", last_wdata, 32'hDEAD_BEEF);
    chk("rw_en_count", en_cnt, 2);
    chk("rw_we_count", we_cnt, 1);

    do_ins(2'b10, 0, 12'h300, 32'h8, 0, s);
    chk("rs_wdata", last_wdata, 32'h8);
    chk("rs_we_count", we_cnt, 1);
    do_ins(2'b11, 0, 12'h300, 32'h8, 0, s);
    chk("rc_rdata", iack_rdata, 32'h8);
    chk("rc_wdata", last_wdata, 32'h0);

    do_ins(2'b10, 1, 12'h300, 32'h5, 0, s);
    chk("nowrite_en_count", en_cnt, 1);
    chk("nowrite_we_count", we_cnt, 0);
    chk("nowrite_latency", iack_cyc - s, 4);
    chk("nowrite_err", iack_err, 0);

    do_ins(2'b01, 0, 12'hC00, 32'h55, 0, s);
    chk("ro_en_count", en_cnt, 1);
    chk("ro_we_count", we_cnt, 0);
    chk("ro_err", iack_err, 1);
    chk("ro_rdata", iack_rdata, 32'hCAFE_0001);

    s = cyc;
    plan_trap(s, 12'h341, 32'h100);
    plan_ins(s + 5, 2'b00, 0, 12'h341, 32'h0, 0);
    start_counts();
    trap_valid = 1; trap_addr = 12'h341; trap_data = 32'h100;
    ins_valid = 1; ins_op = 2'b00; ins_nowrite = 0; ins_addr = 12'h341; ins_operand = 32'h0;
    run_until(1, 1);
    chk("both_trap_latency", tack_cyc - s, 4);
    chk("both_trap_err", tack_err, 0);
    chk("both_ins_latency", iack_cyc - s, 9);
    chk("both_ins_rdata", iack_rdata, 32'h100);

    busy_stuck_lo = 1;
    do_ins(2'b00, 0, 12'h340, 32'h0, 1, s);
    busy_stuck_lo = 0;
    chk("tmo_latency", iack_cyc - s, 2 + TMO);
    chk("tmo_err", iack_err, 1);
    chk("tmo_rdata", iack_rdata, 32'h0);
    step();

    reset_mid(2'b01, 12'h340, 32'h1111_2222, 5, "rst_wr_wait");
    reset_mid(2'b00, 12'h300, 32'h0, 1, "rst_rd_issue");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
